// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM request dispatcher.
//   TYPE_SYS / TYPE_BR : job-type encoding seen on oType / oRes_type
//   SYS_X_W / BR_X_W   : syscall and branch input-vector widths
//   disp_state_e       : dispatcher job-sequencing states
package lstm_pkg;

    localparam logic TYPE_SYS = 1'b1;
    localparam logic TYPE_BR  = 1'b0;

    localparam int SYS_X_W = 64;
    localparam int BR_X_W  = 512;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT
    } disp_state_e;

endpackage

// File: rtl/lstm_req_fifo.sv
// Synchronous FIFO with registered full/empty flags.
//   clk, reset   : clock, synchronous active-high reset (clears pointers/count)
//   push_i       : write request; ignored while full
//   push_data_i  : write data
//   pop_i        : read request; ignored while empty
//   pop_data_o   : oldest entry (valid while not empty)
//   full_o       : registered, count == DEPTH
//   empty_o      : registered, count == 0
module lstm_req_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             full_q;
    logic             empty_q;
    logic             push_ok;
    logic             pop_ok;

    // Gating on the registered flags means a full FIFO refuses a push even
    // in a cycle where it is also being popped.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    // Storage is data only; stale contents are unreachable after reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/lstm_req_dispatcher.sv
// Feeds the LSTM core's run-time data port from two buffered producers.
//   clk, reset              : clock, synchronous active-high reset
//   iEnable                 : parameters loaded, new issues permitted
//   iSys_valid/iSys_data    : syscall vector producer (64-bit)
//   oSys_ready              : syscall FIFO not full
//   iBr_valid/iBr_data      : branch vector producer (512-bit)
//   oBr_ready               : branch FIFO not full
//   iLstm_done              : core idle
//   oNext_valid/oType/oData : one-cycle job start, job type, job payload
//   oRes_valid/oRes_type    : one-cycle job completion and its type
//   oSys_cnt/oBr_cnt        : wrapping per-type issue counters
module lstm_req_dispatcher
    import lstm_pkg::*;
#(
    parameter int SYS_DEPTH = 4,
    parameter int BR_DEPTH  = 2,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iEnable,
    input  logic               iSys_valid,
    input  logic [SYS_X_W-1:0] iSys_data,
    output logic               oSys_ready,
    input  logic               iBr_valid,
    input  logic [BR_X_W-1:0]  iBr_data,
    output logic               oBr_ready,
    input  logic               iLstm_done,
    output logic               oNext_valid,
    output logic               oType,
    output logic [BR_X_W-1:0]  oData,
    output logic               oRes_valid,
    output logic               oRes_type,
    output logic [CNT_W-1:0]   oSys_cnt,
    output logic [CNT_W-1:0]   oBr_cnt
);

    disp_state_e        state_q, state_d;
    logic               last_grant_q;
    logic               type_q;
    logic [BR_X_W-1:0]  data_q;
    logic               res_valid_q;
    logic               res_type_q;
    logic [CNT_W-1:0]   sys_cnt_q;
    logic [CNT_W-1:0]   br_cnt_q;

    logic               start;
    logic               grant_sys;
    logic               sys_pop, br_pop;
    logic               sys_full, sys_empty, br_full, br_empty;
    logic [SYS_X_W-1:0] sys_head;
    logic [BR_X_W-1:0]  br_head;
    logic               complete;

    lstm_req_fifo #(.WIDTH(SYS_X_W), .DEPTH(SYS_DEPTH)) u_sys_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (iSys_valid),
        .push_data_i (iSys_data),
        .pop_i       (sys_pop),
        .pop_data_o  (sys_head),
        .full_o      (sys_full),
        .empty_o     (sys_empty)
    );

    lstm_req_fifo #(.WIDTH(BR_X_W), .DEPTH(BR_DEPTH)) u_br_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (iBr_valid),
        .push_data_i (iBr_data),
        .pop_i       (br_pop),
        .pop_data_o  (br_head),
        .full_o      (br_full),
        .empty_o     (br_empty)
    );

    // Round-robin: a lone non-empty FIFO wins; on a tie the type not granted
    // last time wins.
    assign grant_sys = !sys_empty && (br_empty || (last_grant_q == TYPE_BR));

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (iEnable && iLstm_done && (!sys_empty || !br_empty)) begin
                    state_d = ISSUE;
                    start   = 1'b1;
                end
            end
            // The core needs time to drop oLstm_done after a start pulse, so
            // done is not looked at in ISSUE or GUARD.
            ISSUE:   state_d = GUARD;
            GUARD:   state_d = WAIT;
            WAIT:    if (iLstm_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sys_pop  = start && grant_sys;
    assign br_pop   = start && !grant_sys;
    assign complete = (state_q == WAIT) && iLstm_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= TYPE_BR;
            type_q       <= TYPE_BR;
            data_q       <= '0;
            res_valid_q  <= 1'b0;
            res_type_q   <= TYPE_BR;
            sys_cnt_q    <= '0;
            br_cnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= complete;
            if (complete) res_type_q <= type_q;
            if (start) begin
                if (grant_sys) begin
                    last_grant_q <= TYPE_SYS;
                    type_q       <= TYPE_SYS;
                    data_q       <= {{(BR_X_W - SYS_X_W){1'b0}}, sys_head};
                    sys_cnt_q    <= sys_cnt_q + 1'b1;
                end else begin
                    last_grant_q <= TYPE_BR;
                    type_q       <= TYPE_BR;
                    data_q       <= br_head;
                    br_cnt_q     <= br_cnt_q + 1'b1;
                end
            end
        end
    end

    assign oSys_ready  = !sys_full;
    assign oBr_ready   = !br_full;
    assign oNext_valid = (state_q == ISSUE);
    assign oType       = type_q;
    assign oData       = data_q;
    assign oRes_valid  = res_valid_q;
    assign oRes_type   = res_type_q;
    assign oSys_cnt    = sys_cnt_q;
    assign oBr_cnt     = br_cnt_q;

endmodule

// File: tb/tb_lstm_req_dispatcher.sv
// Self-checking bench for lstm_req_dispatcher: table-driven single-job
// sequence, hand-written corner cases, and randomized traffic checked
// every cycle against a queue-based reference model.
module tb_lstm_req_dispatcher;
    import lstm_pkg::*;

    localparam int SYS_DEPTH = 4;
    localparam int BR_DEPTH  = 2;
    localparam int CNT_W     = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               iEnable;
    logic               iSys_valid;
    logic [63:0]        iSys_data;
    logic               oSys_ready;
    logic               iBr_valid;
    logic [511:0]       iBr_data;
    logic               oBr_ready;
    logic               iLstm_done;
    logic               oNext_valid;
    logic               oType;
    logic [511:0]       oData;
    logic               oRes_valid;
    logic               oRes_type;
    logic [CNT_W-1:0]   oSys_cnt;
    logic [CNT_W-1:0]   oBr_cnt;

    always #5 clk = ~clk;

    lstm_req_dispatcher #(.SYS_DEPTH(SYS_DEPTH), .BR_DEPTH(BR_DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .iEnable     (iEnable),
        .iSys_valid  (iSys_valid),
        .iSys_data   (iSys_data),
        .oSys_ready  (oSys_ready),
        .iBr_valid   (iBr_valid),
        .iBr_data    (iBr_data),
        .oBr_ready   (oBr_ready),
        .iLstm_done  (iLstm_done),
        .oNext_valid (oNext_valid),
        .oType       (oType),
        .oData       (oData),
        .oRes_valid  (oRes_valid),
        .oRes_type   (oRes_type),
        .oSys_cnt    (oSys_cnt),
        .oBr_cnt     (oBr_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_c(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A job is either absent or in flight; an in-flight job finishes on the
    // first edge at least two cycles after its start pulse where the core is
    // done. A new job can start only on an edge with no job in flight.
    logic [63:0]      q_sys[$];
    logic [511:0]     q_br[$];
    bit               m_busy = 1'b0;
    int               m_age = 0;
    logic             m_last = TYPE_BR;
    logic             m_type = 1'b0;
    logic [511:0]     m_data = '0;
    logic             m_nv = 1'b0;
    logic             m_rv = 1'b0;
    logic             m_rt = 1'b0;
    logic [CNT_W-1:0] m_scnt = '0;
    logic [CNT_W-1:0] m_bcnt = '0;
    bit               mchk_en = 1'b0;

    always @(posedge clk) begin
        bit sys_acc, br_acc, pick_sys;
        sys_acc = iSys_valid && (q_sys.size() < SYS_DEPTH);
        br_acc  = iBr_valid && (q_br.size() < BR_DEPTH);
        m_nv = 1'b0;
        m_rv = 1'b0;
        if (reset) begin
            q_sys.delete();
            q_br.delete();
            m_busy = 1'b0;
            m_age  = 0;
            m_last = TYPE_BR;
            m_type = 1'b0;
            m_data = '0;
            m_rt   = 1'b0;
            m_scnt = '0;
            m_bcnt = '0;
        end else begin
            if (m_busy) begin
                if (m_age >= 2 && iLstm_done) begin
                    m_busy = 1'b0;
                    m_rv   = 1'b1;
                    m_rt   = m_type;
                end else begin
                    m_age++;
                end
            end else if (iEnable && iLstm_done && (q_sys.size() + q_br.size() > 0)) begin
                pick_sys = (q_sys.size() > 0) && (q_br.size() == 0 || m_last == TYPE_BR);
                if (pick_sys) begin
                    m_data = {448'd0, q_sys.pop_front()};
                    m_type = TYPE_SYS;
                    m_scnt = m_scnt + 1'b1;
                end else begin
                    m_data = q_br.pop_front();
                    m_type = TYPE_BR;
                    m_bcnt = m_bcnt + 1'b1;
                end
                m_last = m_type;
                m_busy = 1'b1;
                m_age  = 0;
                m_nv   = 1'b1;
            end
            if (sys_acc) q_sys.push_back(iSys_data);
            if (br_acc)  q_br.push_back(iBr_data);
        end
    end

    always @(negedge clk) begin
        if (mchk_en) begin
            check_b("model_sys_ready", oSys_ready, q_sys.size() < SYS_DEPTH);
            check_b("model_br_ready", oBr_ready, q_br.size() < BR_DEPTH);
            check_b("model_next_valid", oNext_valid, m_nv);
            check_b("model_type", oType, m_type);
            check_b("model_res_valid", oRes_valid, m_rv);
            check_b("model_res_type", oRes_type, m_rt);
            check_c("model_sys_cnt", oSys_cnt, m_scnt);
            check_c("model_br_cnt", oBr_cnt, m_bcnt);
            check_w("model_data", oData, m_data);
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct packed {
        logic             en;
        logic             done;
        logic             sv;
        logic [63:0]      sd;
        logic             e_nv;
        logic             e_type;
        logic             e_rv;
        logic             e_rt;
        logic             e_srdy;
        logic [CNT_W-1:0] e_scnt;
        logic             chk_d;
        logic [63:0]      e_d;
    } vec_t;

    vec_t tbl[9];

    task automatic do_reset(input int n);
        reset      = 1'b1;
        iEnable    = 1'b0;
        iLstm_done = 1'b1;
        iSys_valid = 1'b0;
        iBr_valid  = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0]  d1;
        logic [511:0] rr_d[4];
        logic         rr_t[4];
        int           n_iss;
        int           last_c;
        bit           seen;

        d1 = 64'h0102030405060708;
        //             en  dn  sv  sd     nv  ty  rv  rt  srdy scnt    chk  e_d
        tbl[0] = '{1'b1, 1'b1, 1'b1, d1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 64'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, d1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, d1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, d1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, d1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, d1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, d1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 1'b1, d1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, d1};

        iSys_data = '0;
        iBr_data  = '0;

        // Reset defaults
        do_reset(3);
        check_b("rst_sys_ready", oSys_ready, 1'b1);
        check_b("rst_br_ready", oBr_ready, 1'b1);
        check_b("rst_next_valid", oNext_valid, 1'b0);
        check_b("rst_res_valid", oRes_valid, 1'b0);
        check_b("rst_type", oType, 1'b0);
        check_b("rst_res_type", oRes_type, 1'b0);
        check_w("rst_data", oData, 512'd0);
        check_c("rst_sys_cnt", oSys_cnt, 16'd0);
        check_c("rst_br_cnt", oBr_cnt, 16'd0);
        mchk_en = 1'b1;

        // Single syscall job, table driven
        for (int i = 0; i < 9; i++) begin
            iEnable    = tbl[i].en;
            iLstm_done = tbl[i].done;
            iSys_valid = tbl[i].sv;
            iSys_data  = tbl[i].sd;
            @(negedge clk);
            check_b($sformatf("tbl%0d_next_valid", i), oNext_valid, tbl[i].e_nv);
            check_b($sformatf("tbl%0d_type", i), oType, tbl[i].e_type);
            check_b($sformatf("tbl%0d_res_valid", i), oRes_valid, tbl[i].e_rv);
            check_b($sformatf("tbl%0d_res_type", i), oRes_type, tbl[i].e_rt);
            check_b($sformatf("tbl%0d_sys_ready", i), oSys_ready, tbl[i].e_srdy);
            check_c($sformatf("tbl%0d_sys_cnt", i), oSys_cnt, tbl[i].e_scnt);
            if (tbl[i].chk_d) check_w($sformatf("tbl%0d_data", i), oData, {448'd0, tbl[i].e_d});
        end

        // Round-robin
        do_reset(2);
        rr_t[0] = TYPE_SYS; rr_d[0] = {448'd0, 64'h00000000000000A1};
        rr_t[1] = TYPE_BR;  rr_d[1] = {64{8'h80}};
        rr_t[2] = TYPE_SYS; rr_d[2] = {448'd0, 64'h00000000000000A2};
        rr_t[3] = TYPE_BR;  rr_d[3] = {64{8'h7F}};
        iSys_valid = 1'b1; iSys_data = 64'hA1; iBr_valid = 1'b1; iBr_data = {64{8'h80}};
        @(negedge clk);
        iSys_data = 64'hA2; iBr_data = {64{8'h7F}};
        @(negedge clk);
        iSys_valid = 1'b0; iBr_valid = 1'b0;
        iEnable = 1'b1;
        n_iss  = 0;
        last_c = -100;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (oNext_valid) begin
                if (n_iss < 4) begin
                    check_b($sformatf("rr%0d_type", n_iss), oType, rr_t[n_iss]);
                    check_w($sformatf("rr%0d_data", n_iss), oData, rr_d[n_iss]);
                end
                check_b($sformatf("rr%0d_spacing", n_iss), (c - last_c) >= 4, 1'b1);
                last_c = c;
                n_iss++;
            end
        end
        check_c("rr_issues", CNT_W'(n_iss), 16'd4);
        check_c("rr_sys_cnt", oSys_cnt, 16'd2);
        check_c("rr_br_cnt", oBr_cnt, 16'd2);

        // Full FIFOs
        do_reset(2);
        for (int k = 0; k < 4; k++) begin
            iSys_valid = 1'b1;
            iSys_data  = 64'hF0 + 64'(k);
            iBr_valid  = (k < 2);
            iBr_data   = {64{8'(k + 1)}};
            @(negedge clk);
        end
        iSys_valid = 1'b0; iBr_valid = 1'b0;
        check_b("full_sys_ready", oSys_ready, 1'b0);
        check_b("full_br_ready", oBr_ready, 1'b0);
        iSys_valid = 1'b1; iSys_data = 64'hDEAD;
        repeat (3) @(negedge clk);
        iSys_valid = 1'b0;
        check_b("full_sys_ready_hold", oSys_ready, 1'b0);
        iEnable = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (oNext_valid) seen = 1'b1;
        end
        check_b("full_issue_seen", seen, 1'b1);
        check_b("full_issue_type", oType, TYPE_SYS);
        check_b("full_sys_ready_back", oSys_ready, 1'b1);
        repeat (40) @(negedge clk);
        check_c("full_sys_cnt", oSys_cnt, 16'd4);
        check_c("full_br_cnt", oBr_cnt, 16'd2);

        // Done gating
        do_reset(2);
        iEnable = 1'b1; iLstm_done = 1'b0;
        iSys_valid = 1'b1; iSys_data = 64'h55;
        @(negedge clk);
        iSys_valid = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (oNext_valid) seen = 1'b1;
        end
        check_b("gate_no_issue", seen, 1'b0);
        iLstm_done = 1'b1;
        @(negedge clk);
        check_b("gate_issue", oNext_valid, 1'b1);

        // Reset while in WAIT with one entry queued
        iLstm_done = 1'b0;
        iSys_valid = 1'b1; iSys_data = 64'h66;
        @(negedge clk);
        iSys_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; iLstm_done = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (oRes_valid) seen = 1'b1;
        end
        reset = 1'b0;
        check_b("rstjob_no_res", seen, 1'b0);
        check_c("rstjob_sys_cnt", oSys_cnt, 16'd0);
        check_b("rstjob_sys_ready", oSys_ready, 1'b1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (oNext_valid || oRes_valid) seen = 1'b1;
        end
        check_b("rstjob_no_issue", seen, 1'b0);

        // Randomized traffic against the reference model
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            iEnable    = ($urandom_range(0, 3) != 0);
            iLstm_done = ($urandom_range(0, 9) < 7);
            iSys_valid = ($urandom_range(0, 9) < 4);
            iSys_data  = {$urandom, $urandom};
            iBr_valid  = ($urandom_range(0, 9) < 3);
            for (int w = 0; w < 16; w++) iBr_data[w*32 +: 32] = $urandom;
            @(negedge clk);
        end
        reset = 1'b0;
        iSys_valid = 1'b0;
        iBr_valid  = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
